aes_encrypt_iter: RTL and testbench
===================================

Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core. Computes one round per clock and is the forward-direction counterpart of the decrypt block.
- Uses the same round-key interface as decrypt: keyword is round key 0; subkey0..subkey9 are round keys 1..10, supplied by the existing key schedule.
- Sits beside decrypt in the AES datapath. Its result can feed decrypt directly for loopback.

Parameters:
- NROUNDS, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- HCLK  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- ena  in  1  start request; sampled only in IDLE.
- keyword  in  128  round key 0, used for the initial AddRoundKey.
- subkey0..subkey9  in  128 each  round keys 1..10.
- inData  in  128  plaintext block; captured on the accepted ena edge.
- result  out  128  ciphertext; registered and held until the next completion or reset.
- busy  out  1  high while a block is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Byte order follows FIPS-197:
  - state byte 0 = bits [127:120]; column-major; column c = bytes 4c..4c+3.
  - Round keys use the same order.
- FSM has two states, IDLE and RUN. It also holds a 4-bit round counter rnd (1..10) and a 128-bit state register st.
- Reset (async, any time, including mid-RUN):
  - FSM -> IDLE, rnd = 0, st = 0, result = 0, busy = 0, done = 0.
  - An in-flight block is discarded; done never pulses for it.
- IDLE, ena=1 at edge N:
  - st <= inData ^ keyword; rnd <= 1; FSM -> RUN; busy = 1 after edge N.
- IDLE, ena=0: nothing changes; result holds.
- RUN, rnd = r in 1..9: st <= MixColumns(ShiftRows(SubBytes(st))) ^ round key r (subkey[r-1]); rnd <= r+1.
- RUN, rnd = 10:
  - result <= ShiftRows(SubBytes(st)) ^ subkey9 (no MixColumns).
  - done <= 1 for exactly one cycle; busy <= 0; FSM -> IDLE.
- Latency: ena accepted at edge N -> result valid and done high after edge N+10.
- Throughput: a new ena is accepted at edge N+11 at the earliest, i.e. one block per 11 cycles when ena is held high.
- ena while busy is ignored; it is not queued.
- inData may change after the accepting edge.
- keyword/subkeys must be stable from the accepting edge through edge N+10. Changes mid-RUN corrupt only the current block.
- Datapath arithmetic:
  - SubBytes: 16 forward S-box lookups (combinational 256-entry ROM).
  - MixColumns over GF(2^8) with reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
  - Per column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- done and busy are never high in the same cycle.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: keyword=000102030405060708090a0b0c0d0e0f; subkey0..9 = d6aa74fdd2af72fadaa678f1d6ab76fe ... 13111d7fe3944a17f307a78b4d2b30c5; inData=00112233445566778899aabbccddeeff; ena pulse at edge N.
  - Response: result=69c4e0d86a7b0430d8cdb78070b4c55a and done=1 exactly after edge N+10; busy high edges N..N+9.
- FIPS-197 Appendix B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c with its Appendix A.1 round keys; inData=3243f6a8885a308d313198a2e0370734.
  - Response: result=3925841d02dc09fbdc118597196a0b32.
- Busy rejection:
  - Stimulus: during C.1 run, pulse ena at edge N+4 with inData=ffff...ff.
  - Response: ignored; result still 69c4e0d8...; single done pulse at N+10; no second done.
- Back-to-back:
  - Stimulus: ena held high across C.1 then Appendix B operands (swapped after edge N).
  - Response: done at N+10 and N+21; busy low only during cycle N+10..N+11; both results correct.
- Reset mid-operation:
  - Stimulus: assert n_rst=0 asynchronously between edges N+5 and N+6.
  - Response: result=0, busy=0, done=0 immediately; no done pulse; a fresh C.1 run afterwards passes.
- Loopback:
  - Stimulus: feed result into decrypt with the same keyword/subkeys.
  - Response: decrypt returns 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption, one round per clock.
// Ports:
//   HCLK            clock, rising edge
//   n_rst           async active-low reset
//   ena             start request, sampled only when idle
//   keyword         round key 0 (initial AddRoundKey)
//   subkey0..9      round keys 1..10
//   inData          plaintext, captured on the accepting edge
//   result          ciphertext, held until next completion or reset
//   busy            high while a block is in flight
//   done            one-cycle completion pulse
module aes_encrypt_iter #(
  parameter int NROUNDS = 10
) (
  input  logic         HCLK,
  input  logic         n_rst,
  input  logic         ena,
  input  logic [127:0] keyword,
  input  logic [127:0] subkey0,
  input  logic [127:0] subkey1,
  input  logic [127:0] subkey2,
  input  logic [127:0] subkey3,
  input  logic [127:0] subkey4,
  input  logic [127:0] subkey5,
  input  logic [127:0] subkey6,
  input  logic [127:0] subkey7,
  input  logic [127:0] subkey8,
  input  logic [127:0] subkey9,
  input  logic [127:0] inData,
  output logic [127:0] result,
  output logic         busy,
  output logic         done
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] i);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(i[8*k +: 8]);
    return o;
  endfunction

  // Byte 4c+r (row r, column c) takes row r from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] i);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = i[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] i);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = i[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] st, st_nxt, result_nxt;
  logic         done_nxt;
  logic [127:0] rkey, sr, mc;

  // Round key r comes from subkey[r-1].
  always_comb begin
    rkey = subkey9;
    case (rnd)
      4'd1:    rkey = subkey0;
      4'd2:    rkey = subkey1;
      4'd3:    rkey = subkey2;
      4'd4:    rkey = subkey3;
      4'd5:    rkey = subkey4;
      4'd6:    rkey = subkey5;
      4'd7:    rkey = subkey6;
      4'd8:    rkey = subkey7;
      4'd9:    rkey = subkey8;
      default: rkey = subkey9;
    endcase
  end

  assign sr = shift_rows(sub_bytes(st));
  assign mc = mix_columns(sr);

  always_comb begin
    state_nxt  = state;
    rnd_nxt    = rnd;
    st_nxt     = st;
    result_nxt = result;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (ena) begin
        st_nxt    = inData ^ keyword;
        rnd_nxt   = 4'd1;
        state_nxt = RUN;
      end
      RUN: if (rnd == 4'(NROUNDS)) begin
        // Final round skips MixColumns.
        result_nxt = sr ^ rkey;
        done_nxt   = 1'b1;
        state_nxt  = IDLE;
      end else begin
        st_nxt  = mc ^ rkey;
        rnd_nxt = rnd + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      rnd    <= '0;
      st     <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rnd    <= rnd_nxt;
      st     <= st_nxt;
      result <= result_nxt;
      done   <= done_nxt;
    end
  end

  // Leaving RUN coincides with done rising, so the two never overlap.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors, busy rejection, back-to-back,
// mid-run reset, and random blocks against a byte-matrix AES model.
module tb_aes_encrypt_iter;
  logic         HCLK, n_rst, ena, busy, done;
  logic [127:0] keyword, inData, result;
  logic [127:0] subkey0, subkey1, subkey2, subkey3, subkey4;
  logic [127:0] subkey5, subkey6, subkey7, subkey8, subkey9;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_m  [256];
  logic [7:0]   isbox_m [256];
  logic [127:0] rk_m    [11];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_encrypt_iter #(.NROUNDS(10)) dut (
    .HCLK(HCLK), .n_rst(n_rst), .ena(ena), .keyword(keyword),
    .subkey0(subkey0), .subkey1(subkey1), .subkey2(subkey2), .subkey3(subkey3),
    .subkey4(subkey4), .subkey5(subkey5), .subkey6(subkey6), .subkey7(subkey7),
    .subkey8(subkey8), .subkey9(subkey9), .inData(inData),
    .result(result), .busy(busy), .done(done)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[a]  = s;
      isbox_m[s] = 8'(a);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_m[0][127-8*k -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 10) ? t[4*c+r] :
                     gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^
                     t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_m[rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Inverse cipher, standing in for the decrypt block in loopback checks.
  function automatic logic [127:0] dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rk_m[10][127-8*k -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = isbox_m[s[4*((c-r+4)%4)+r]];
      for (int k = 0; k < 16; k++) t[k] = t[k] ^ rk_m[rd][127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 0) ? t[4*c+r] :
                     gmul(8'h0e, t[4*c+r]) ^ gmul(8'h0b, t[4*c+(r+1)%4]) ^
                     gmul(8'h0d, t[4*c+(r+2)%4]) ^ gmul(8'h09, t[4*c+(r+3)%4]);
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic load_keys();
    keyword = rk_m[0];  subkey0 = rk_m[1];  subkey1 = rk_m[2];  subkey2 = rk_m[3];
    subkey3 = rk_m[4];  subkey4 = rk_m[5];  subkey5 = rk_m[6];  subkey6 = rk_m[7];
    subkey7 = rk_m[8];  subkey8 = rk_m[9];  subkey9 = rk_m[10];
  endtask

  // Pulse ena at edge N and check the exact busy/done timeline through N+11.
  task automatic run_exact(input string tag, input logic [127:0] pt, input logic [127:0] exp);
    inData = pt;
    ena = 1'b1;
    tick();
    ena = 1'b0;
    inData = ~pt;
    chk({tag, "_busy_N"}, 128'(busy), 128'(1));
    for (int i = 1; i < 10; i++) begin
      tick();
      chk({tag, "_busy_run"}, 128'({busy, done}), 128'(2'b10));
    end
    tick();
    chk({tag, "_done_N10"}, 128'({busy, done}), 128'(2'b01));
    chk({tag, "_result"}, result, exp);
    tick();
    chk({tag, "_done_once"}, 128'(done), 128'(0));
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) n++;
    end
    chk(tag, 128'(n), 128'(0));
  endtask

  initial begin
    int lat;
    logic [127:0] key, pt, exp;
    build_sbox();
    n_rst = 1'b0; ena = 1'b0; inData = '0;
    expand(C1_KEY);
    load_keys();
    tick(); tick();
    chk("reset_result", result, 128'h0);
    chk("reset_busy_done", 128'({busy, done}), 128'(0));
    n_rst = 1'b1;
    tick();

    // FIPS-197 C.1 with exact timing, then loopback and idle hold.
    run_exact("c1", C1_PT, C1_CT);
    chk("c1_loopback", dec(result), C1_PT);
    tick(); tick(); tick();
    chk("idle_hold", result, C1_CT);
    chk("idle_busy", 128'(busy), 128'(0));

    // Appendix B.
    expand(B_KEY);
    load_keys();
    run_exact("appb", B_PT, B_CT);

    // ena while busy is dropped, not queued.
    expand(C1_KEY);
    load_keys();
    inData = C1_PT; ena = 1'b1;
    tick();
    ena = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    ena = 1'b1; inData = '1;
    tick();
    ena = 1'b0;
    chk("rej_busy", 128'(busy), 128'(1));
    for (int i = 5; i < 10; i++) tick();
    tick();
    chk("rej_done", 128'(done), 128'(1));
    chk("rej_result", result, C1_CT);
    count_dones("rej_no_second_done", 15);

    // Back-to-back with ena held: C.1 then Appendix B.
    inData = C1_PT; ena = 1'b1;
    tick();
    inData = B_PT;
    for (int i = 1; i < 10; i++) tick();
    tick();
    chk("b2b_done1", 128'({busy, done}), 128'(2'b01));
    chk("b2b_result1", result, C1_CT);
    expand(B_KEY);
    load_keys();
    tick();
    ena = 1'b0;
    chk("b2b_busy2", 128'({busy, done}), 128'(2'b10));
    for (int i = 12; i < 21; i++) tick();
    tick();
    chk("b2b_done2", 128'({busy, done}), 128'(2'b01));
    chk("b2b_result2", result, B_CT);

    // Reset between edges N+5 and N+6.
    expand(C1_KEY);
    load_keys();
    inData = C1_PT; ena = 1'b1;
    tick();
    ena = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_result", result, 128'h0);
    chk("mid_rst_busy_done", 128'({busy, done}), 128'(0));
    tick();
    n_rst = 1'b1;
    count_dones("mid_rst_no_done", 15);
    run_exact("post_rst_c1", C1_PT, C1_CT);

    // Random keys/plaintexts against the model, with bounded wait.
    for (int n = 0; n < 6; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(key);
      load_keys();
      exp = enc(pt);
      inData = pt; ena = 1'b1;
      tick();
      ena = 1'b0;
      inData = '0;
      lat = 0;
      while (!done && lat < 20) begin
        tick();
        lat++;
      end
      chk("rand_latency", 128'(lat), 128'(10));
      chk("rand_result", result, exp);
      chk("rand_loopback", dec(result), pt);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
